ps2_key_buffer: RTL

Sits between the PS/2 keyboard receiver and the CPU's memory-mapped I/O. It takes raw set-2 scan codes, removes break (F0) and extended (E0) prefixes, and tracks shift state. It translates make codes to ASCII and queues characters in a small FIFO, which the CPU pops one at a time. This replaces the hex-digit debug display of raw codes with a real character stream.

---
 rtl/ps2_key_buffer_pkg.sv | 17 +
 rtl/ps2_set2_to_ascii.sv | 67 ++++++
 rtl/ps2_key_buffer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ps2_key_buffer_pkg.sv
// Shared constants for the PS/2 key buffer: set-2 prefix bytes, shift
// scan codes and the prefix FSM state encoding.
package ps2_key_buffer_pkg;

    localparam logic [7:0] CODE_BREAK  = 8'hF0;
    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } prefix_state_e;

endpackage

// File: rtl/ps2_set2_to_ascii.sv
// Combinational set-2 make code to ASCII translator; hit is low for any
// code that has no printable or control character.
module ps2_set2_to_ascii (
    input  logic [7:0] code,
    input  logic       shift,
    output logic [7:0] ascii,
    output logic       hit
);

    logic [7:0] lower;

    always_comb begin
        lower = 8'h00;
        ascii = 8'h00;
        hit   = 1'b0;
        case (code)
            8'h1C: lower = 8'h61;
            8'h32: lower = 8'h62;
            8'h21: lower = 8'h63;
            8'h23: lower = 8'h64;
            8'h24: lower = 8'h65;
            8'h2B: lower = 8'h66;
            8'h34: lower = 8'h67;
            8'h33: lower = 8'h68;
            8'h43: lower = 8'h69;
            8'h3B: lower = 8'h6A;
            8'h42: lower = 8'h6B;
            8'h4B: lower = 8'h6C;
            8'h3A: lower = 8'h6D;
            8'h31: lower = 8'h6E;
            8'h44: lower = 8'h6F;
            8'h4D: lower = 8'h70;
            8'h15: lower = 8'h71;
            8'h2D: lower = 8'h72;
            8'h1B: lower = 8'h73;
            8'h2C: lower = 8'h74;
            8'h3C: lower = 8'h75;
            8'h2A: lower = 8'h76;
            8'h1D: lower = 8'h77;
            8'h22: lower = 8'h78;
            8'h35: lower = 8'h79;
            8'h1A: lower = 8'h7A;
            8'h45: begin hit = 1'b1; ascii = shift ? 8'h29 : 8'h30; end
            8'h16: begin hit = 1'b1; ascii = shift ? 8'h21 : 8'h31; end
            8'h1E: begin hit = 1'b1; ascii = shift ? 8'h40 : 8'h32; end
            8'h26: begin hit = 1'b1; ascii = shift ? 8'h23 : 8'h33; end
            8'h25: begin hit = 1'b1; ascii = shift ? 8'h24 : 8'h34; end
            8'h2E: begin hit = 1'b1; ascii = shift ? 8'h25 : 8'h35; end
            8'h36: begin hit = 1'b1; ascii = shift ? 8'h5E : 8'h36; end
            8'h3D: begin hit = 1'b1; ascii = shift ? 8'h26 : 8'h37; end
            8'h3E: begin hit = 1'b1; ascii = shift ? 8'h2A : 8'h38; end
            8'h46: begin hit = 1'b1; ascii = shift ? 8'h28 : 8'h39; end
            8'h29: begin hit = 1'b1; ascii = 8'h20; end
            8'h5A: begin hit = 1'b1; ascii = 8'h0D; end
            8'h66: begin hit = 1'b1; ascii = 8'h08; end
            8'h76: begin hit = 1'b1; ascii = 8'h1B; end
            8'h0D: begin hit = 1'b1; ascii = 8'h09; end
            default: ;
        endcase
        // Letters share one path: upper case is lower case minus 0x20.
        if (lower != 8'h00) begin
            hit   = 1'b1;
            ascii = shift ? (lower - 8'h20) : lower;
        end
    end

endmodule

// File: rtl/ps2_key_buffer.sv
// PS/2 scan code to ASCII character queue: strips break/extended prefixes,
// tracks shift, and buffers translated characters in a fall-through FIFO.
module ps2_key_buffer
    import ps2_key_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_code,
    input  logic       key_strobe,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       key_valid,
    output logic       overflow,
    output logic       shift_held
);

    prefix_state_e state_q;
    logic          strobe_q;
    logic          lshift_q, rshift_q;
    logic          push_q;
    logic [7:0]    push_char_q;
    logic [7:0]    xlat_ascii;
    logic          xlat_hit;
    logic          ev;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q;
    logic          full, pop, do_write, drop;

    assign ev         = key_strobe & ~strobe_q;
    assign shift_held = lshift_q | rshift_q;

    ps2_set2_to_ascii u_xlat (
        .code  (key_code),
        .shift (shift_held),
        .ascii (xlat_ascii),
        .hit   (xlat_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) strobe_q <= 1'b0;
        else     strobe_q <= key_strobe;
    end

    // Prefix FSM; the translated character is registered here and written
    // into the FIFO on the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            push_q      <= 1'b0;
            push_char_q <= 8'h00;
        end else begin
            push_q <= 1'b0;
            if (ev) begin
                case (state_q)
                    ST_IDLE: begin
                        if (key_code == CODE_BREAK)       state_q <= ST_BRK;
                        else if (key_code == CODE_EXT)    state_q <= ST_EXT;
                        else if (key_code == CODE_LSHIFT) lshift_q <= 1'b1;
                        else if (key_code == CODE_RSHIFT) rshift_q <= 1'b1;
                        else if (xlat_hit) begin
                            push_q      <= 1'b1;
                            push_char_q <= xlat_ascii;
                        end
                    end
                    ST_BRK: begin
                        if (key_code == CODE_LSHIFT) lshift_q <= 1'b0;
                        if (key_code == CODE_RSHIFT) rshift_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    ST_EXT: begin
                        state_q <= (key_code == CODE_BREAK) ? ST_EXT_BRK : ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign key_valid = (count_q != '0);
    assign pop       = rd_en & key_valid;
    assign do_write  = push_q & (~full | pop);
    assign drop      = push_q & full & ~pop;
    assign rd_data   = key_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign overflow  = overflow_q;

    always_comb begin
        count_d = count_q;
        if (do_write && !pop)      count_d = count_q + 1'b1;
        else if (!do_write && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_write) mem_q[wr_ptr_q] <= push_char_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_write) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (drop)     overflow_q <= 1'b1;
            else if (pop) overflow_q <= 1'b0;
        end
    end

endmodule
